// File: rtl/junction_controller_if.sv
// junction_controller_if: pedestrian request in, lamp drives and status out
interface junction_controller_if;
  logic ped_req;
  logic ns_red, ns_amber, ns_green;
  logic ew_red, ew_amber, ew_green;
  logic walk, ped_wait;
  modport master (
    input  ped_req,
    output ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_wait
  );
  modport slave (
    output ped_req,
    input  ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_wait
  );
endinterface

// File: rtl/junction_controller.sv
// junction_controller: two-road traffic light sequencer with a pedestrian walk phase
// served from the all-red clearance.
module junction_controller #(
  parameter int GREEN_CYC  = 8,
  parameter int AMBER_CYC  = 3,
  parameter int RA_CYC     = 2,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  junction_controller_if.master   bus
);
  localparam int M1 = GREEN_CYC > AMBER_CYC ? GREEN_CYC : AMBER_CYC;
  localparam int M2 = RA_CYC > ALLRED_CYC ? RA_CYC : ALLRED_CYC;
  localparam int M3 = M1 > M2 ? M1 : M2;
  localparam int MAXP = M3 > WALK_CYC ? M3 : WALK_CYC;
  localparam int CW = MAXP > 1 ? $clog2(MAXP) : 1;
  typedef enum logic [2:0] {ALL_RED, NS_RA, NS_G, NS_A, EW_RA, EW_G, EW_A, WALK} state_t;
  state_t state, state_nx;
  logic road, road_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic ped_wait, ped_nx;
  function automatic logic [CW-1:0] dwell(state_t s);
    return s inside {NS_G, EW_G}   ? CW'(GREEN_CYC - 1) :
           s inside {NS_A, EW_A}   ? CW'(AMBER_CYC - 1) :
           s inside {NS_RA, EW_RA} ? CW'(RA_CYC - 1) :
           s == WALK               ? CW'(WALK_CYC - 1) : CW'(ALLRED_CYC - 1);
  endfunction
  // road: 0 selects north-south next, 1 east-west
  always_comb begin
    state_nx = state;
    road_nx  = road;
    if (cnt == '0)
      case (state)
        ALL_RED: state_nx = ped_wait ? WALK : road ? EW_RA : NS_RA;
        WALK:    state_nx = road ? EW_RA : NS_RA;
        NS_RA:   state_nx = NS_G;
        NS_G:    state_nx = NS_A;
        NS_A:    state_nx = ALL_RED;
        EW_RA:   state_nx = EW_G;
        EW_G:    state_nx = EW_A;
        EW_A:    state_nx = ALL_RED;
      endcase
    if (state_nx == ALL_RED && state != ALL_RED) road_nx = !road;
    cnt_nx = state_nx != state ? dwell(state_nx) : cnt - 1'b1;
    ped_nx = (state_nx == WALK && state != WALK) ? 1'b0 :
             (state != WALK && bus.ped_req) ? 1'b1 : ped_wait;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ALL_RED;
      road     <= 1'b0;
      cnt      <= CW'(ALLRED_CYC - 1);
      ped_wait <= 1'b0;
    end else begin
      state    <= state_nx;
      road     <= road_nx;
      cnt      <= cnt_nx;
      ped_wait <= ped_nx;
    end
  assign bus.ns_red   = !(state inside {NS_G, NS_A});
  assign bus.ns_amber = state inside {NS_RA, NS_A};
  assign bus.ns_green = state == NS_G;
  assign bus.ew_red   = !(state inside {EW_G, EW_A});
  assign bus.ew_amber = state inside {EW_RA, EW_A};
  assign bus.ew_green = state == EW_G;
  assign bus.walk     = state == WALK;
  assign bus.ped_wait = ped_wait;
endmodule

// File: tb/tb_junction_controller.sv
// tb_junction_controller: random and directed pedestrian traffic checked against a
// phase-queue reference model.
module tb_junction_controller;
  localparam int G = 8, A = 3, RA = 2, AR = 2, W = 5;
  // lamp vector: {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk}
  localparam logic [6:0] P_AR = 7'b100_100_0, P_W = 7'b100_100_1;
  localparam logic [6:0] P_NRA = 7'b110_100_0, P_NG = 7'b001_100_0, P_NA = 7'b010_100_0;
  localparam logic [6:0] P_ERA = 7'b100_110_0, P_EG = 7'b100_001_0, P_EA = 7'b100_010_0;
  typedef struct {logic [6:0] pat; int len; bit decide;} seg_t;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  junction_controller_if bus();
  junction_controller #(.GREEN_CYC(G), .AMBER_CYC(A), .RA_CYC(RA), .ALLRED_CYC(AR), .WALK_CYC(W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  seg_t segs[$];
  seg_t cur;
  int left, checks = 0, errors = 0, walk_cnt = 0, cyc = 0, last_nra = -1, period = 0;
  bit pend, road;
  logic [6:0] prev;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic seg_t mk(logic [6:0] p, int n, bit d);
    seg_t s;
    s.pat = p; s.len = n; s.decide = d;
    return s;
  endfunction
  function automatic logic [6:0] lamps();
    return {bus.ns_red, bus.ns_amber, bus.ns_green, bus.ew_red, bus.ew_amber, bus.ew_green, bus.walk};
  endfunction
  task automatic model_reset();
    segs.delete();
    cur = mk(P_AR, AR, 1); left = AR; pend = 0; road = 0;
  endtask
  // advance the model across one rising edge with the given request level
  task automatic model_step(input bit req);
    bit was_walk, enter_walk;
    was_walk = cur.pat[0]; enter_walk = 0;
    left--;
    if (left == 0) begin
      if (cur.decide) begin
        if (pend) segs.push_back(mk(P_W, W, 0));
        segs.push_back(mk(road ? P_ERA : P_NRA, RA, 0));
        segs.push_back(mk(road ? P_EG : P_NG, G, 0));
        segs.push_back(mk(road ? P_EA : P_NA, A, 0));
        segs.push_back(mk(P_AR, AR, 1));
        road = !road;
      end
      cur = segs.pop_front(); left = cur.len; enter_walk = cur.pat[0];
    end
    pend = enter_walk ? 1'b0 : (!was_walk && req) ? 1'b1 : pend;
  endtask
  task automatic cycle(input bit req);
    logic [6:0] l;
    l = lamps();
    check("lamps", l, cur.pat);
    check("ped_wait", bus.ped_wait, pend);
    check("one_green", bus.ns_green & bus.ew_green, 0);
    check("green_vs_red", (bus.ns_green & !bus.ew_red) | (bus.ew_green & !bus.ns_red), 0);
    check("walk_clear", bus.walk & (bus.ns_green | bus.ns_amber | bus.ew_green | bus.ew_amber), 0);
    if (bus.walk) walk_cnt++;
    if (l == P_NRA && prev != P_NRA) begin
      if (last_nra >= 0) period = cyc - last_nra;
      last_nra = cyc;
    end
    prev = l; cyc++;
    bus.ped_req = req;
    model_step(req);
    @(negedge clk);
  endtask
  task automatic do_reset();
    bus.ped_req = 0;
    rst_n = 0;
    #1;
    check("rst_lamps", lamps(), P_AR);
    check("rst_ped_wait", bus.ped_wait, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_hold", lamps(), P_AR);
    rst_n = 1;
    prev = '0; last_nra = -1; period = 0; walk_cnt = 0;
  endtask
  initial begin
    bus.ped_req = 0;
    #2;
    do_reset();
    repeat (70) cycle(0);
    check("period", period, 30);
    check("no_walk_idle", walk_cnt, 0);
    do_reset();
    repeat (5) cycle(0);
    cycle(1);
    check("pulse_pw", bus.ped_wait, 1);
    repeat (40) cycle(0);
    check("walk_len", walk_cnt, W);
    do_reset();
    cycle(0);
    cycle(1);
    check("ra_after_expiry", lamps(), P_NRA);
    check("expiry_pw", bus.ped_wait, 1);
    repeat (40) cycle(0);
    check("late_walk_len", walk_cnt, W);
    do_reset();
    repeat (60) cycle(1);
    do_reset();
    repeat (17) cycle(0);
    cycle(1);
    repeat (3) cycle(0);
    check("pre_rst_ewg", lamps(), P_EG);
    check("pre_rst_pw", bus.ped_wait, 1);
    do_reset();
    repeat (20) cycle(0);
    do_reset();
    repeat (1000) cycle($urandom_range(0, 7) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/junction_controller.md
JUNCTION_CONTROLLER -- requirements
Module: junction_controller

Interface
REQ-001 Parameter GREEN_CYC, default 8: green dwell in clk cycles.
REQ-002 Parameter AMBER_CYC, default 3: amber dwell in clk cycles.
REQ-003 Parameter RA_CYC, default 2: red+amber dwell in clk cycles.
REQ-004 Parameter ALLRED_CYC, default 2: all-red clearance dwell in clk cycles.
REQ-005 Parameter WALK_CYC, default 5: pedestrian walk dwell in clk cycles.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 ped_req  input  1  pedestrian button, synchronous to clk, level or pulse.
REQ-009 ns_red, ns_amber, ns_green  output  1 each  north-south lamp drives.
REQ-010 ew_red, ew_amber, ew_green  output  1 each  east-west lamp drives.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 ped_wait  output  1  "request pending" indicator.

Function
REQ-013 Moore FSM, states: ALL_RED, NS_RA, NS_G, NS_A, EW_RA, EW_G, EW_A, WALK; outputs decoded from the state register and ped_wait flop only.
REQ-014 Lamp decode: NS_RA -> ns red+amber; NS_G -> ns green; NS_A -> ns amber; EW_* likewise on ew lamps; every lamp not driven by the state is off except red, which is on for a road whenever that road is not in RA/G/A.
REQ-015 ALL_RED and WALK: ns_red=ew_red=1, all amber/green 0; walk=1 only in WALK.
REQ-016 Each state lasts exactly its parameter count of cycles: dwell counter loaded with N-1 on entry, decremented each cycle, transition on the edge where it reads 0.
REQ-017 Road order: NS_RA -> NS_G -> NS_A -> ALL_RED; EW_RA -> EW_G -> EW_A -> ALL_RED.
REQ-018 next_road flag (NS/EW) toggles on entry to ALL_RED from NS_A or EW_A; it selects the next RA state.
REQ-019 On ALL_RED expiry: if ped_wait=1, go to WALK; else go to next_road's RA state.
REQ-020 On WALK expiry: go to next_road's RA state (no extra all-red).
REQ-021 ped_wait sets on any rising edge with ped_req=1 while state is not WALK; clears on the edge entering WALK; set wins over nothing else; ped_req during WALK is ignored.
REQ-022 ped_req asserted in the same cycle ALL_RED expires is captured but serviced at the next ALL_RED, not the current one.
REQ-023 At most one green lamp across both roads in every cycle; a green never directly follows a red without RA, and RA never follows green.
REQ-024 Parameters shall be >= 1; counter width $clog2 of the largest parameter, minimum 1 bit; no wrap beyond 0.
REQ-025 Default no-pedestrian cycle period is 30 clk cycles; a serviced request adds exactly WALK_CYC cycles.

Reset
REQ-026 rst_n=0 immediately (asynchronously) forces state ALL_RED, next_road=NS, counter=ALLRED_CYC-1, ped_wait=0.
REQ-027 During reset: ns_red=ew_red=1, all amber/green=0, walk=0, ped_wait=0.
REQ-028 Reset asserted mid-phase (including mid-green or WALK) aborts the phase, discards any pending request, and restarts from REQ-026 state.
REQ-029 First edge after rst_n release counts as ALL_RED cycle 1.

Verification
REQ-030 Release reset, ped_req=0 -> ALL_RED 2, NS_RA 2, NS_G 8, NS_A 3, ALL_RED 2, EW_RA 2, EW_G 8, EW_A 3, ALL_RED 2 cycles, then NS_RA; period 30.
REQ-031 One-cycle ped_req pulse in NS_G -> ped_wait=1 next cycle; after NS_A/ALL_RED, WALK 5 cycles with walk=1, both reds on, ped_wait=0, then EW_RA.
REQ-032 ped_req held high through WALK -> ped_wait stays 0 in WALK, sets on first cycle after WALK, serviced at following ALL_RED.
REQ-033 ped_req on the exact ALL_RED expiry edge -> no WALK now; next RA entered; WALK occurs at next ALL_RED.
REQ-034 rst_n pulsed low mid-EW_G with ped_wait=1 -> outputs go all-red without waiting for clk, ped_wait=0; after release sequence restarts at ALL_RED then NS_RA.
REQ-035 Run 1000 cycles with random ped_req -> assertion never fires: >1 green, green while other road not red, walk with any green/amber.
